// File: rtl/maze_defs.sv
// Shared definitions for the maze position link: grid size, packet width,
// transmit FSM states and the position-to-packet encoder.
package maze_defs;

   localparam int GRID_ROWS = 4;
   localparam int GRID_COLS = 5;
   localparam int PKT_W     = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      HOLD = 2'd2,
      GAP  = 2'd3
   } state_t;

   // Packet layout on the GPIO bus is {col[2:0], row[1:0]}.
   function automatic logic [PKT_W-1:0] encode(input logic [1:0] row, input logic [2:0] col);
      return {col, row};
   endfunction

endpackage

// File: rtl/pos_fifo.sv
// Synchronous position queue. Pointers carry an extra wrap bit so that
// full and empty are distinguished without a separate occupancy counter.
module pos_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 5
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic [W-1:0] i_data,
   output logic [W-1:0] o_data,
   output logic         o_full,
   output logic         o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] r_mem [DEPTH];
   logic [AW:0]  r_wr;
   logic [AW:0]  r_rd;
   logic         w_do_push;
   logic         w_do_pop;

   assign o_empty   = (r_wr == r_rd);
   assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign o_data    = r_mem[r_rd[AW-1:0]];

   // Pointer update; both pointers wrap naturally modulo 2*DEPTH.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (w_do_push) r_wr <= r_wr + 1'b1;
         if (w_do_pop)  r_rd <= r_rd + 1'b1;
      end
   end

   // Storage write; contents are don't-care while the queue is empty.
   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/maze_packet_tx.sv
// Transmit side of the robot-position link: filters and queues grid
// positions, then presents each one on the GPIO bus with a long strobe
// window followed by a short quiet gap. Raises SOUND_EN once the maze is
// finished and the queue has drained.
module maze_packet_tx
   import maze_defs::*;
#(
   parameter int HOLD_CYCLES = 25000,
   parameter int GAP_CYCLES  = 250,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic             CLOCK,
   input  logic             RESET,
   input  logic             POS_VALID,
   output logic             POS_READY,
   input  logic [1:0]       POS_ROW,
   input  logic [2:0]       POS_COL,
   input  logic             DONE,
   output logic [PKT_W-1:0] PACKET,
   output logic             PACKET_STROBE,
   output logic             SOUND_EN,
   output logic             BUSY,
   output logic             ERR_RANGE
);

   localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [PKT_W-1:0] r_load;
   logic [PKT_W-1:0] r_packet;
   logic             r_strobe;
   logic [PKT_W-1:0] r_last_enq;
   logic             r_err;
   logic             r_done_pending;
   logic             r_sound;

   logic             w_full;
   logic             w_empty;
   logic [PKT_W-1:0] w_head;
   logic [PKT_W-1:0] w_enc;
   logic             w_accept;
   logic             w_bad_col;
   logic             w_dup;
   logic             w_push;
   logic             w_pop;

   assign w_enc     = encode(POS_ROW, POS_COL);
   assign w_accept  = POS_VALID && !w_full;
   assign w_bad_col = (POS_COL > 3'(GRID_COLS - 1));
   assign w_dup     = (w_enc == r_last_enq);
   assign w_push    = w_accept && !w_bad_col && !w_dup;
   assign w_pop     = (r_state == IDLE) && !w_empty;

   assign POS_READY     = !w_full;
   assign PACKET        = r_packet;
   assign PACKET_STROBE = r_strobe;
   assign SOUND_EN      = r_sound;
   assign ERR_RANGE     = r_err;
   assign BUSY          = (r_state != IDLE) || !w_empty;

   pos_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (PKT_W)
   ) u_fifo (
      .i_clk   (CLOCK),
      .i_rst   (RESET),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_enc),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Input filter: drop out-of-range columns (flagged) and repeats of the last queued position.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         r_last_enq <= '0;
         r_err      <= 1'b0;
      end else begin
         if (w_accept && w_bad_col) r_err <= 1'b1;
         if (w_push) r_last_enq <= w_enc;
      end
   end

   // Completion tracking: remember DONE, then enable the tone once the link has drained.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         r_done_pending <= 1'b0;
         r_sound        <= 1'b0;
      end else begin
         if (DONE) r_done_pending <= 1'b1;
         if (r_done_pending && (r_state == IDLE) && w_empty) r_sound <= 1'b1;
      end
   end

   // Transmit sequencer: pop, present the packet with strobe for the hold window, then rest.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_load   <= '0;
         r_packet <= '0;
         r_strobe <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (!w_empty) begin
                  r_load  <= w_head;
                  r_state <= LOAD;
               end
            end
            LOAD: begin
               r_packet <= r_load;
               r_strobe <= 1'b1;
               r_cnt    <= '0;
               r_state  <= HOLD;
            end
            HOLD: begin
               if (r_cnt == HOLD_LAST) begin
                  r_strobe <= 1'b0;
                  r_cnt    <= '0;
                  r_state  <= GAP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            GAP: begin
               if (r_cnt == GAP_LAST) begin
                  r_cnt   <= '0;
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
